// File: rtl/multicycle_ctrl_if.sv
// Control-unit <-> datapath bundle: instruction/flags in, strobes and debug state out.
// The instret output exists only when MCTRL_INSTRET_EN is defined.
interface multicycle_ctrl_if;
    logic [31:0] ins;
    logic        zero;
    logic        INT;
    logic        pc_write;
    logic        INT_sel;
    logic        RegWrite;
    logic        ALUSrc;
    logic        MemRead;
    logic        MemWrite;
    logic        Mem2Reg;
    logic [2:0]  op;
    logic        isbranch;
    logic        isjump;
    logic        illegal;
    logic [2:0]  state;
`ifdef MCTRL_INSTRET_EN
    logic [31:0] instret;

    modport master (
        input  ins, zero, INT,
        output pc_write, INT_sel, RegWrite, ALUSrc, MemRead, MemWrite, Mem2Reg,
        output op, isbranch, isjump, illegal, state, instret
    );
    modport slave (
        output ins, zero, INT,
        input  pc_write, INT_sel, RegWrite, ALUSrc, MemRead, MemWrite, Mem2Reg,
        input  op, isbranch, isjump, illegal, state, instret
    );
`else
    modport master (
        input  ins, zero, INT,
        output pc_write, INT_sel, RegWrite, ALUSrc, MemRead, MemWrite, Mem2Reg,
        output op, isbranch, isjump, illegal, state
    );
    modport slave (
        output ins, zero, INT,
        input  pc_write, INT_sel, RegWrite, ALUSrc, MemRead, MemWrite, Mem2Reg,
        input  op, isbranch, isjump, illegal, state
    );
`endif
endinterface

// File: rtl/multicycle_ctrl.sv
// Moore multi-cycle control FSM (BOOT/FETCH/DECODE/EXEC/MEM/WB) for the RISC-V datapath.
// Define MCTRL_INSTRET_EN to add the 32-bit retired-instruction counter.
module multicycle_ctrl #(
    parameter int ENTRY_CYCLES = 1
) (
    input logic               clk,
    input logic               reset,
    multicycle_ctrl_if.master ctrl
);
    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        BOOT   = 3'd5
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] ir;
    logic [1:0]  boot_cnt;
    logic        boot_last;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic is_r_op, is_r, is_addi, is_lw, is_sw, is_beq, is_jal, legal;
    logic final_state, in_body, pc_write, trap;
    logic unused_bits;

    assign opcode    = ir[6:0];
    assign funct3    = ir[14:12];
    assign boot_last = (boot_cnt == 2'(ENTRY_CYCLES - 1));

    assign is_r_op = (opcode == 7'h33);
    assign is_r    = is_r_op && (funct3 inside {3'b000, 3'b110, 3'b111, 3'b010});
    assign is_addi = (opcode == 7'h13);
    assign is_lw   = (opcode == 7'h03);
    assign is_sw   = (opcode == 7'h23);
    assign is_beq  = (opcode == 7'h63);
    assign is_jal  = (opcode == 7'h6F);
    assign legal   = is_r || is_addi || is_lw || is_sw || is_beq || is_jal;

    // zero is only informational here; unused IR fields are folded away too
    assign unused_bits = ^{ctrl.zero, ir[31], ir[29:15], ir[11:7]};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= BOOT;
            ir       <= 32'd0;
            boot_cnt <= 2'd0;
        end else begin
            state_q <= state_d;
            if (state_q == FETCH) ir <= ctrl.ins;
            if (state_q == BOOT && !boot_last) boot_cnt <= boot_cnt + 2'd1;
        end
    end

    // Illegal instructions pass through EXEC with no strobes and trap from WB
    always_comb begin
        state_d = state_q;
        case (state_q)
            BOOT:    state_d = boot_last ? FETCH : BOOT;
            FETCH:   state_d = DECODE;
            DECODE:  state_d = EXEC;
            EXEC: begin
                if (is_beq || is_jal)    state_d = FETCH;
                else if (is_lw || is_sw) state_d = MEM;
                else                     state_d = WB;
            end
            MEM:     state_d = is_lw ? WB : FETCH;
            WB:      state_d = FETCH;
            default: state_d = BOOT;
        endcase
    end

    always_comb begin
        final_state = 1'b0;
        case (state_q)
            BOOT:    final_state = boot_last;
            EXEC:    final_state = is_beq || is_jal;
            MEM:     final_state = is_sw;
            WB:      final_state = 1'b1;
            default: final_state = 1'b0;
        endcase
    end

    assign in_body  = (state_q == DECODE) || (state_q == EXEC) || (state_q == MEM) || (state_q == WB);
    assign trap     = (state_q == WB) && !legal;
    // Reset gates every write strobe so an aborted instruction commits nothing
    assign pc_write = final_state && !reset;

    always_comb begin
        ctrl.op = 3'b000;
        if (in_body) begin
            ctrl.op = 3'b010;
            if (is_beq) ctrl.op = 3'b110;
            else if (is_r) begin
                case (funct3)
                    3'b000:  ctrl.op = ir[30] ? 3'b110 : 3'b010;
                    3'b110:  ctrl.op = 3'b001;
                    3'b111:  ctrl.op = 3'b000;
                    3'b010:  ctrl.op = 3'b111;
                    default: ctrl.op = 3'b010;
                endcase
            end
        end
    end

    assign ctrl.state    = state_q;
    assign ctrl.pc_write = pc_write;
    assign ctrl.INT_sel  = pc_write && (ctrl.INT || state_q == BOOT || trap);
    assign ctrl.ALUSrc   = in_body && !(is_r_op || is_beq);
    assign ctrl.MemRead  = is_lw && (state_q == MEM || state_q == WB);
    assign ctrl.Mem2Reg  = is_lw && (state_q == WB);
    assign ctrl.MemWrite = is_sw && (state_q == MEM) && !reset;
    assign ctrl.RegWrite = (is_r || is_addi || is_lw) && (state_q == WB) && !reset;
    assign ctrl.isbranch = is_beq && (state_q == EXEC);
    assign ctrl.isjump   = is_jal && (state_q == EXEC);
    assign ctrl.illegal  = !legal && (state_q == DECODE);

`ifdef MCTRL_INSTRET_EN
    logic [31:0] instret_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            instret_q <= 32'd0;
        end else if (pc_write && state_q != BOOT && !trap) begin
            instret_q <= instret_q + 32'd1;
        end
    end

    assign ctrl.instret = instret_q;
`endif
endmodule
